// File: rtl/ahb_master_arbiter.sv
// Two-master to one AHB-lite master port arbiter.
// Each master sees its own HREADY; a transfer that cannot go to the bus in
// the cycle it is accepted is parked in a per-master pending register and
// replayed as NONSEQ once it wins arbitration with the system bus ready.
module ahb_master_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] HADDR_M0,
    input  logic [31:0] HADDR_M1,
    input  logic [1:0]  HTRANS_M0,
    input  logic [1:0]  HTRANS_M1,
    input  logic        HWRITE_M0,
    input  logic        HWRITE_M1,
    input  logic [2:0]  HSIZE_M0,
    input  logic [2:0]  HSIZE_M1,
    input  logic [31:0] HWDATA_M0,
    input  logic [31:0] HWDATA_M1,
    output logic        HREADY_M0,
    output logic        HREADY_M1,
    output logic [31:0] HRDATA_M0,
    output logic [31:0] HRDATA_M1,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA
);

    // Pending request per master (flag plus captured address-phase payload)
    logic        r_pend_0;
    logic        r_pend_1;
    logic [31:0] r_addr_0;
    logic [31:0] r_addr_1;
    logic        r_write_0;
    logic        r_write_1;
    logic [2:0]  r_size_0;
    logic [2:0]  r_size_1;

    // Bus data phase tracking and round-robin history
    logic        r_dvalid;
    logic        r_owner;
    logic        r_last_grant;

    logic        w_ready_0;
    logic        w_ready_1;
    logic        w_acc_0;
    logic        w_acc_1;
    logic        w_req_0;
    logic        w_req_1;
    logic        w_fwd;
    logic        w_gnt;
    logic [31:0] w_addr;
    logic        w_write;
    logic [2:0]  w_size;
    logic        w_unused_seq_bits;

    // Per-master ready: the owner of the bus data phase follows HREADY,
    // everyone else is stalled only while holding a pending request.
    // Depends on registers and HREADY only, never on the master HTRANS.
    always_comb begin
        w_ready_0 = (r_dvalid && !r_owner) ? HREADY : !r_pend_0;
        w_ready_1 = (r_dvalid &&  r_owner) ? HREADY : !r_pend_1;
        if (HRESET) begin
            w_ready_0 = 1'b1;
            w_ready_1 = 1'b1;
        end
    end

    assign HREADY_M0 = w_ready_0;
    assign HREADY_M1 = w_ready_1;

    // SEQ and NONSEQ are treated alike; only bit 1 marks a real transfer.
    assign w_acc_0 = HTRANS_M0[1] & w_ready_0;
    assign w_acc_1 = HTRANS_M1[1] & w_ready_1;
    assign w_req_0 = r_pend_0 | w_acc_0;
    assign w_req_1 = r_pend_1 | w_acc_1;
    assign w_unused_seq_bits = HTRANS_M0[0] ^ HTRANS_M1[0];

    // Arbitration: only while the bus is ready; ties go to M0 in fixed
    // priority mode, otherwise to the master that did not win last time.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_fwd = 1'b0;
        w_gnt = 1'b0;
        if (HREADY && !HRESET) begin
            if (w_req_0 && w_req_1) begin
                w_fwd = 1'b1;
                w_gnt = (FIXED_PRIO != 0) ? 1'b0 : ~r_last_grant;
            end else if (w_req_0) begin
                w_fwd = 1'b1;
                w_gnt = 1'b0;
            end else if (w_req_1) begin
                w_fwd = 1'b1;
                w_gnt = 1'b1;
            end
        end
    end

    // Address-phase source: the pending register when one is held, else the live bus.
    always_comb begin
        w_addr  = HADDR_M0;
        w_write = HWRITE_M0;
        w_size  = HSIZE_M0;
        if (w_gnt) begin
            if (r_pend_1) begin
                w_addr  = r_addr_1;
                w_write = r_write_1;
                w_size  = r_size_1;
            end else begin
                w_addr  = HADDR_M1;
                w_write = HWRITE_M1;
                w_size  = HSIZE_M1;
            end
        end else if (r_pend_0) begin
            w_addr  = r_addr_0;
            w_write = r_write_0;
            w_size  = r_size_0;
        end
    end

    // Every forwarded beat is a standalone NONSEQ; the bus never sees SEQ.
    assign HTRANS    = w_fwd ? 2'b10 : 2'b00;
    assign HADDR     = w_addr;
    assign HWRITE    = w_write;
    assign HSIZE     = w_size;
    assign HWDATA    = r_owner ? HWDATA_M1 : HWDATA_M0;
    assign HRDATA_M0 = HRDATA;
    assign HRDATA_M1 = HRDATA;

    // Control state: pending flags, data-phase owner and arbitration history.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_pend_0     <= 1'b0;
            r_pend_1     <= 1'b0;
            r_dvalid     <= 1'b0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            if (w_fwd) begin
                r_dvalid     <= 1'b1;
                r_owner      <= w_gnt;
                r_last_grant <= w_gnt;
            end else if (HREADY) begin
                r_dvalid     <= 1'b0;
            end

            if (w_fwd && !w_gnt) begin
                r_pend_0 <= 1'b0;
            end else if (w_acc_0) begin
                r_pend_0 <= 1'b1;
            end

            if (w_fwd && w_gnt) begin
                r_pend_1 <= 1'b0;
            end else if (w_acc_1) begin
                r_pend_1 <= 1'b1;
            end
        end
    end

    // Pending payload capture on every acceptance; only meaningful while the flag is set.
    // NOTE: payload registers carry no reset; the pend flags alone qualify them.
    always_ff @(posedge HCLK) begin
        if (w_acc_0) begin
            r_addr_0  <= HADDR_M0;
            r_write_0 <= HWRITE_M0;
            r_size_0  <= HSIZE_M0;
        end
        if (w_acc_1) begin
            r_addr_1  <= HADDR_M1;
            r_write_1 <= HWRITE_M1;
            r_size_1  <= HSIZE_M1;
        end
    end

endmodule
